// File: rtl/button_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// button_conditioner_pkg
//   Shared definitions for the button conditioner:
//     - db_state_t : 2-bit per-button debounce state encoding
//     - START/RED/GREEN/BLUE : button index constants (also priority order,
//                              lowest index wins)
//     - first_one / multi_hot : arbitration helpers over the press vector
// -----------------------------------------------------------------------------
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_PEND = 2'd3
    } db_state_t;

    localparam int START   = 0;
    localparam int RED     = 1;
    localparam int GREEN   = 2;
    localparam int BLUE    = 3;
    localparam int NUM_BTN = 4;

    // Isolate the lowest set bit: lowest index is the highest priority.
    function automatic logic [NUM_BTN-1:0] first_one(input logic [NUM_BTN-1:0] v);
        return v & (~v + NUM_BTN'(1));
    endfunction

    // True when two or more bits are set.
    function automatic logic multi_hot(input logic [NUM_BTN-1:0] v);
        return (v & (v - NUM_BTN'(1))) != '0;
    endfunction

endpackage

// File: rtl/button_conditioner_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//   One button channel: two-flop synchronizer, stability counter and a
//   RELEASED/PRESS_PEND/PRESSED/RELEASE_PEND state machine. A level change is
//   accepted after DEBOUNCE_CYCLES consecutive mismatching synchronized
//   samples. Emits a registered one-cycle press pulse on the
//   PRESS_PEND -> PRESSED transition only.
//
//   Ports:
//     clk   : clock, rising edge
//     rst_n : asynchronous active-low reset
//     raw   : raw asynchronous button level (1 = pressed)
//     press : one-cycle pulse per accepted press
// -----------------------------------------------------------------------------
module btn_debounce
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [CNT_W-1:0] cnt;
    db_state_t        state;

    logic mismatch;
    logic accept;

    assign mismatch = (sync2 != level);
    assign accept   = mismatch && (cnt == LAST);

    // NOTE: every register here is state, so all assignments are non-blocking;
    // blocking ones would let sync2 see this edge's sync1 and collapse the
    // synchronizer into a single flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            state <= RELEASED;
            press <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            press <= 1'b0;

            if (!mismatch) begin
                cnt <= '0;
            end else if (accept) begin
                cnt   <= '0;
                level <= ~level;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            case (state)
                RELEASED: begin
                    if (mismatch) state <= PRESS_PEND;
                end
                PRESS_PEND: begin
                    if (accept) begin
                        state <= PRESSED;
                        press <= 1'b1;
                    end else if (!mismatch) begin
                        state <= RELEASED;
                    end
                end
                PRESSED: begin
                    if (mismatch) state <= RELEASE_PEND;
                end
                RELEASE_PEND: begin
                    if (accept)         state <= RELEASED;
                    else if (!mismatch) state <= PRESSED;
                end
                default: state <= RELEASED;
            endcase
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//   Conditions four raw buttons (Start, Red, Green, Blue) into registered,
//   mutually exclusive one-cycle press pulses for the code detector.
//
//   Optional feature (macro BTN_CONFLICT_REJECT_EN):
//     defined   : two or more presses accepted on the same edge produce a
//                 Conflict pulse instead of any button pulse.
//     undefined : same-edge presses resolved by priority Start > R > G > B;
//                 losers are dropped, Conflict stays 0.
//
//   Ports:
//     Clk      : clock, rising edge
//     Rst      : asynchronous active-low reset
//     StartBtn, RBtn, GBtn, BBtn : raw asynchronous button levels
//     Start, R, G, B : one-cycle press pulses
//     Conflict : one-cycle pulse on rejected simultaneous presses
// -----------------------------------------------------------------------------
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8
) (
    input  logic Clk,
    input  logic Rst,
    input  logic StartBtn,
    input  logic RBtn,
    input  logic GBtn,
    input  logic BBtn,
    output logic Start,
    output logic R,
    output logic G,
    output logic B,
    output logic Conflict
);

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] press;
    logic [NUM_BTN-1:0] win;
    logic               conflict_nxt;

    assign raw[START] = StartBtn;
    assign raw[RED]   = RBtn;
    assign raw[GREEN] = GBtn;
    assign raw[BLUE]  = BBtn;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_debounce (
            .clk   (Clk),
            .rst_n (Rst),
            .raw   (raw[i]),
            .press (press[i])
        );
    end

    // NOTE: defaults first so every path assigns every output; otherwise the
    // tool infers latches for the signals a branch leaves untouched.
    always_comb begin
        win          = '0;
        conflict_nxt = 1'b0;
`ifdef BTN_CONFLICT_REJECT_EN
        if (multi_hot(press)) conflict_nxt = 1'b1;
        else                  win          = press;
`else
        win = first_one(press);
`endif
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            Start    <= 1'b0;
            R        <= 1'b0;
            G        <= 1'b0;
            B        <= 1'b0;
            Conflict <= 1'b0;
        end else begin
            Start    <= win[START];
            R        <= win[RED];
            G        <= win[GREEN];
            B        <= win[BLUE];
            Conflict <= conflict_nxt;
        end
    end

endmodule
